// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the CPU-side request/response handshake and the data_memory bus
// seen by load_store_unit.
//
//   Request  : req_valid, req_ready, req_write, req_size, req_signed,
//              req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_fault
//   Memory   : mem_read, mem_write, mem_address, mem_write_data,
//              mem_read_data
//
// modport slave  : the load/store unit itself.
// modport master : its environment (MEM stage issuing requests plus the
//                  data_memory returning mem_read_data).
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;

    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator-side controller for a 64-bit, dword-addressed data_memory.
// Accepts one load/store at a time and turns it into mem_read / mem_write
// cycles. Byte/half/word/dword accesses; loads are zero- or sign-extended,
// sub-dword stores are performed as read-modify-write.
//
// Ports:
//   read_clk  : clock, all state changes on posedge
//   reset     : synchronous, active-low
//   bus       : load_store_unit_if.slave (request, response, memory bus)
//
// Flow (one cycle per state):
//   load            IDLE -> RD -> EXT -> RESP
//   dword store     IDLE -> WR -> RESP
//   sub-dword store IDLE -> RD -> MERGE -> WR -> RESP
//   fault           IDLE -> RESP
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic             read_clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] EXT   = 3'd3;
    localparam logic [2:0] WR    = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    logic [2:0]  state_reg, state_next;
    logic        ready_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [63:0] addr_reg;
    // Holds the store data at accept; for sub-dword stores it is replaced
    // by the merged dword in MERGE, so WR always drives this register.
    logic [63:0] data_reg;
    logic [63:0] rdata_reg;
    logic        fault_reg;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic [2:0]  offset;
    logic [7:0]  size_mask;
    logic [7:0]  byte_en;
    logic [63:0] wdata_lane;
    logic [63:0] merged_data;
    logic [63:0] rd_shift;
    logic [63:0] load_ext;

    // ready_reg is only ever high in IDLE, so it doubles as the accept gate.
    assign accept = ready_reg & bus.req_valid;

    // Fault checks operate on the live request so the decision is made at
    // the accept edge.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = |bus.req_addr[1:0];
            default: misaligned = |bus.req_addr[2:0];
        endcase
    end

    assign out_of_range = (bus.req_addr[63:3] >= 61'(MEM_WORDS));

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned || out_of_range)
                        state_next = RESP;
                    else if (bus.req_write && bus.req_size == 2'd3)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = write_reg ? MERGE : EXT;
            MERGE:   state_next = WR;
            EXT:     state_next = RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Lane selection (little-endian, lane offset = addr[2:0] bytes)
    // ---------------------------------------------------------------------
    assign offset = addr_reg[2:0];

    always_comb begin
        size_mask = 8'h00;
        case (size_reg)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Alignment is guaranteed by the fault check, so the shifted mask never
    // wraps past byte 7.
    assign byte_en    = size_mask << offset;
    assign wdata_lane = data_reg << {offset, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign merged_data[8*gi +: 8] = byte_en[gi] ? wdata_lane[8*gi +: 8]
                                                        : bus.mem_read_data[8*gi +: 8];
        end
    endgenerate

    // Load extension: bring the addressed field down to bit 0 first.
    assign rd_shift = bus.mem_read_data >> {offset, 3'b000};

    always_comb begin
        load_ext = 64'd0;
        case (size_reg)
            2'd0:    load_ext = signed_reg ? {{56{rd_shift[7]}},  rd_shift[7:0]}
                                           : {56'd0, rd_shift[7:0]};
            2'd1:    load_ext = signed_reg ? {{48{rd_shift[15]}}, rd_shift[15:0]}
                                           : {48'd0, rd_shift[15:0]};
            2'd2:    load_ext = signed_reg ? {{32{rd_shift[31]}}, rd_shift[31:0]}
                                           : {32'd0, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge read_clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b0;
            write_reg  <= 1'b0;
            size_reg   <= 2'd0;
            signed_reg <= 1'b0;
            addr_reg   <= 64'd0;
            data_reg   <= 64'd0;
            rdata_reg  <= 64'd0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered so req_ready stays low in the reset cycle and rises
            // on the first edge after reset is released.
            ready_reg <= (state_next == IDLE);

            if (accept) begin
                write_reg  <= bus.req_write;
                size_reg   <= bus.req_size;
                signed_reg <= bus.req_signed;
                addr_reg   <= bus.req_addr;
                data_reg   <= bus.req_wdata;
            end

            if (state_reg == MERGE)
                data_reg <= merged_data;

            // Response fields update only when entering RESP and hold after.
            // RESP is reached straight from IDLE only on a fault.
            if (state_next == RESP) begin
                fault_reg <= (state_reg == IDLE);
                rdata_reg <= (state_reg == EXT) ? load_ext : 64'd0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: memory bus is a pure function of the state so it is quiet
    // (all zero) whenever no access is in progress, including after reset.
    // ---------------------------------------------------------------------
    assign bus.req_ready      = ready_reg;
    assign bus.mem_read       = (state_reg == RD);
    assign bus.mem_write      = (state_reg == WR);
    assign bus.mem_address    = (state_reg == RD || state_reg == WR)
                                ? {addr_reg[63:3], 3'b000} : 64'd0;
    assign bus.mem_write_data = (state_reg == WR) ? data_reg : 64'd0;
    assign bus.resp_valid     = (state_reg == RESP);
    assign bus.resp_rdata     = rdata_reg;
    assign bus.resp_fault     = fault_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit with a behavioural data_memory
// (registered read) and a scoreboard queue of expected responses.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    localparam int MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .read_clk (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    // Behavioural data_memory plus a bench-side seeding port.
    logic [63:0] mem [MEM_WORDS];
    logic        seed_en = 1'b0;
    logic [9:0]  seed_idx = '0;
    logic [63:0] seed_val = '0;

    always @(posedge clk) begin
        if (bus.mem_read)
            bus.mem_read_data <= mem[bus.mem_address[12:3]];
        if (bus.mem_write)
            mem[bus.mem_address[12:3]] <= bus.mem_write_data;
        if (seed_en)
            mem[seed_idx] <= seed_val;
    end

    // Bus monitor
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rule_viol = 0;
    logic [63:0] last_addr = '0;

    always @(negedge clk) begin
        if (bus.mem_read) begin
            rd_cnt    <= rd_cnt + 1;
            last_addr <= bus.mem_address;
        end
        if (bus.mem_write) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= bus.mem_address;
        end
        if (bus.mem_read && bus.mem_write)
            rule_viol <= rule_viol + 1;
        if (!bus.mem_read && !bus.mem_write &&
            (bus.mem_address != 64'd0 || bus.mem_write_data != 64'd0))
            rule_viol <= rule_viol + 1;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [63:0] ref_mem [8];

    // Reference load: gather bytes one at a time, then sign-fill.
    function automatic logic [63:0] model_load(logic [63:0] w, logic [2:0] off,
                                               logic [1:0] sz, logic sg);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = w[8*(int'(off) + i) +: 8];
        if (sg && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++)
                v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] model_store(logic [63:0] w, logic [2:0] off,
                                                logic [1:0] sz, logic [63:0] d);
        int          n;
        logic [63:0] r;
        n = 1 << sz;
        r = w;
        for (int i = 0; i < n; i++)
            r[8*(int'(off) + i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic seed_word(input logic [9:0] idx, input logic [63:0] val);
        @(negedge clk);
        seed_en  = 1'b1;
        seed_idx = idx;
        seed_val = val;
        @(posedge clk);
        #1 seed_en = 1'b0;
    endtask

    // Drives one request and waits (bounded) for its response. Latency is
    // the number of cycles from the accept edge to the resp_valid cycle.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [63:0] addr, input logic [63:0] wd,
                           output logic [63:0] rd, output logic flt, output int lat,
                           output int nrd, output int nwr, output logic [63:0] maddr);
        int guard;
        int rd0;
        int wr0;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 20);
        rd    = bus.resp_rdata;
        flt   = bus.resp_fault;
        nrd   = rd_cnt - rd0;
        nwr   = wr_cnt - wr0;
        maddr = last_addr;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write} !== 5'b0 ||
            bus.resp_rdata !== 64'd0 || bus.mem_address !== 64'd0 || bus.mem_write_data !== 64'd0) begin
            $display("FAIL reset_outputs: ready=%b valid=%b fault=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, required all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write,
                     bus.resp_rdata, bus.mem_address, bus.mem_write_data);
            tests_failed++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b required 1", bus.req_ready);
            tests_failed++;
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_loads();
        logic [63:0] addrs [3] = '{64'h17, 64'h12, 64'h14};
        logic [1:0]  sizes [3] = '{2'd0, 2'd1, 2'd2};
        logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] exps  [3] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_4433,
                                   64'hFFFF_FFFF_8877_6655};
        logic [63:0] rd, maddr;
        logic        flt;
        int          lat, nrd, nwr;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            e.rdata = exps[i];
            e.fault = 1'b0;
            e.lat   = 3;
            sb_q.push_back(e);
            run_req(1'b0, sizes[i], sgns[i], addrs[i], 64'd0, rd, flt, lat, nrd, nwr, maddr);
            e = sb_q.pop_front();
            $display("[TB] load addr=%h size=%0d signed=%b -> rdata=%h fault=%b lat=%0d",
                     addrs[i], sizes[i], sgns[i], rd, flt, lat);
            tests_run++;
            if (rd !== e.rdata || flt !== e.fault) begin
                $display("FAIL load_data[%0d]: got rdata=%h fault=%b required rdata=%h fault=%b",
                         i, rd, flt, e.rdata, e.fault);
                tests_failed++;
            end
            tests_run++;
            if (lat !== e.lat || nrd !== 1 || nwr !== 0 || maddr !== 64'h10) begin
                $display("FAIL load_bus[%0d]: got lat=%0d reads=%0d writes=%0d addr=%h required lat=%0d reads=1 writes=0 addr=10",
                         i, lat, nrd, nwr, maddr, e.lat);
                tests_failed++;
            end
        end
    endtask

    task automatic test_store_byte();
        logic [63:0] rd, maddr;
        logic        flt;
        int          lat, nrd, nwr;
        exp_t        e;
        e.rdata = 64'd0;
        e.fault = 1'b0;
        e.lat   = 4;
        sb_q.push_back(e);
        run_req(1'b1, 2'd0, 1'b0, 64'h11, 64'hAB, rd, flt, lat, nrd, nwr, maddr);
        e = sb_q.pop_front();
        $display("[TB] store byte addr=11 data=AB -> lat=%0d reads=%0d writes=%0d word2=%h",
                 lat, nrd, nwr, mem[2]);
        tests_run++;
        if (lat !== e.lat || rd !== e.rdata || flt !== e.fault || nrd !== 1 || nwr !== 1) begin
            $display("FAIL store_byte_bus: got lat=%0d rdata=%h fault=%b reads=%0d writes=%0d required lat=4 rdata=0 fault=0 reads=1 writes=1",
                     lat, rd, flt, nrd, nwr);
            tests_failed++;
        end
        tests_run++;
        if (mem[2] !== 64'h8877_6655_4433_AB11) begin
            $display("FAIL store_byte_mem: got %h required 887766554433ab11", mem[2]);
            tests_failed++;
        end
    endtask

    task automatic test_store_dword();
        logic [63:0] rd, maddr;
        logic        flt;
        int          lat, nrd, nwr;
        exp_t        e;
        e.rdata = 64'd0;
        e.fault = 1'b0;
        e.lat   = 2;
        sb_q.push_back(e);
        run_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, rd, flt, lat, nrd, nwr, maddr);
        e = sb_q.pop_front();
        $display("[TB] store dword addr=18 -> lat=%0d reads=%0d writes=%0d", lat, nrd, nwr);
        tests_run++;
        if (lat !== e.lat || rd !== e.rdata || flt !== e.fault || nrd !== 0 || nwr !== 1 || maddr !== 64'h18) begin
            $display("FAIL store_dword_bus: got lat=%0d rdata=%h fault=%b reads=%0d writes=%0d addr=%h required lat=2 rdata=0 fault=0 reads=0 writes=1 addr=18",
                     lat, rd, flt, nrd, nwr, maddr);
            tests_failed++;
        end
        e.rdata = 64'h0123_4567_89AB_CDEF;
        e.lat   = 3;
        sb_q.push_back(e);
        run_req(1'b0, 2'd3, 1'b1, 64'h18, 64'd0, rd, flt, lat, nrd, nwr, maddr);
        e = sb_q.pop_front();
        $display("[TB] load dword addr=18 -> rdata=%h lat=%0d", rd, lat);
        tests_run++;
        if (rd !== e.rdata || lat !== e.lat || flt !== e.fault) begin
            $display("FAIL load_dword: got rdata=%h lat=%0d fault=%b required rdata=%h lat=%0d fault=0",
                     rd, lat, flt, e.rdata, e.lat);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_op();
        int wr0;
        wr0 = wr_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h11;
        bus.req_wdata  = 64'hCD;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);   // RD
        @(negedge clk);   // MERGE
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write} !== 5'b0 ||
            bus.resp_rdata !== 64'd0 || bus.mem_address !== 64'd0 || bus.mem_write_data !== 64'd0) begin
            $display("FAIL reset_mid_outputs: ready=%b valid=%b fault=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, required all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write,
                     bus.resp_rdata, bus.mem_address, bus.mem_write_data);
            tests_failed++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL reset_mid_ready: got %b required 1", bus.req_ready);
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if (wr_cnt !== wr0 || mem[2] !== 64'h8877_6655_4433_AB11) begin
            $display("FAIL reset_mid_mem: got writes=%0d word2=%h required writes=0 word2=887766554433ab11",
                     wr_cnt - wr0, mem[2]);
            tests_failed++;
        end
        $display("[TB] reset during MERGE: word2=%h", mem[2]);
    endtask

    task automatic test_faults();
        logic [63:0] addrs [2] = '{64'h13, 64'(8 * MEM_WORDS)};
        logic [1:0]  sizes [2] = '{2'd1, 2'd3};
        logic [63:0] rd, maddr;
        logic        flt;
        int          lat, nrd, nwr;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            e.rdata = 64'd0;
            e.fault = 1'b1;
            e.lat   = 1;
            sb_q.push_back(e);
            run_req(1'b0, sizes[i], 1'b0, addrs[i], 64'd0, rd, flt, lat, nrd, nwr, maddr);
            e = sb_q.pop_front();
            $display("[TB] fault addr=%h size=%0d -> fault=%b rdata=%h lat=%0d reads=%0d writes=%0d",
                     addrs[i], sizes[i], flt, rd, lat, nrd, nwr);
            tests_run++;
            if (flt !== e.fault || rd !== e.rdata || lat !== e.lat || nrd !== 0 || nwr !== 0) begin
                $display("FAIL fault[%0d]: got fault=%b rdata=%h lat=%0d reads=%0d writes=%0d required fault=1 rdata=0 lat=1 reads=0 writes=0",
                         i, flt, rd, lat, nrd, nwr);
                tests_failed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [3] = '{64'h10, 64'h16, 64'h10};
        logic [1:0]  sizes [3] = '{2'd0, 2'd1, 2'd2};
        logic        sgns  [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] rd, maddr;
        logic        flt;
        int          lat, nrd, nwr;
        exp_t        e;
        e.fault = 1'b0;
        e.lat   = 3;
        e.rdata = 64'h11;                  sb_q.push_back(e);
        e.rdata = 64'hFFFF_FFFF_FFFF_8877; sb_q.push_back(e);
        e.rdata = 64'h4433_AB11;           sb_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, sizes[i], sgns[i], addrs[i], 64'd0, rd, flt, lat, nrd, nwr, maddr);
            e = sb_q.pop_front();
            $display("[TB] b2b load addr=%h size=%0d -> rdata=%h lat=%0d", addrs[i], sizes[i], rd, lat);
            tests_run++;
            if (rd !== e.rdata || flt !== e.fault || lat !== e.lat) begin
                $display("FAIL b2b[%0d]: got rdata=%h fault=%b lat=%0d required rdata=%h fault=0 lat=3",
                         i, rd, flt, lat, e.rdata);
                tests_failed++;
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, maddr, wd, addr;
        logic        flt, wr, sg;
        logic [1:0]  sz;
        logic [2:0]  off;
        int          lat, nrd, nwr, w, n;
        exp_t        e;
        for (int k = 0; k < 8; k++) begin
            ref_mem[k] = {$urandom, $urandom};
            seed_word(10'(k), ref_mem[k]);
        end
        for (int t = 0; t < 24; t++) begin
            wr  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sg  = 1'($urandom_range(0, 1));
            n   = 1 << sz;
            off = 3'($urandom_range(0, 8 / n - 1) * n);
            w   = $urandom_range(0, 7);
            wd  = {$urandom, $urandom};
            addr = 64'(w * 8) | 64'(off);
            e.fault = 1'b0;
            if (wr) begin
                e.rdata    = 64'd0;
                e.lat      = (sz == 2'd3) ? 2 : 4;
                ref_mem[w] = model_store(ref_mem[w], off, sz, wd);
            end else begin
                e.rdata = model_load(ref_mem[w], off, sz, sg);
                e.lat   = 3;
            end
            sb_q.push_back(e);
            run_req(wr, sz, sg, addr, wd, rd, flt, lat, nrd, nwr, maddr);
            e = sb_q.pop_front();
            $display("[TB] rand %s addr=%h size=%0d signed=%b -> rdata=%h lat=%0d",
                     wr ? "store" : "load", addr, sz, sg, rd, lat);
            tests_run++;
            if (rd !== e.rdata || flt !== e.fault || lat !== e.lat) begin
                $display("FAIL rand[%0d]: got rdata=%h fault=%b lat=%0d required rdata=%h fault=0 lat=%0d",
                         t, rd, flt, lat, e.rdata, e.lat);
                tests_failed++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (mem[k] !== ref_mem[k]) begin
                $display("FAIL rand_mem[%0d]: got %h required %h", k, mem[k], ref_mem[k]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_bus_rules();
        tests_run++;
        if (rule_viol !== 0) begin
            $display("FAIL bus_rules: got %0d violation cycles required 0", rule_viol);
            tests_failed++;
        end
        $display("[TB] bus rules: %0d violation cycles", rule_viol);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        test_reset();
        seed_word(10'd2, 64'h8877_6655_4433_2211);
        test_loads();
        test_store_byte();
        test_store_dword();
        test_reset_mid_op();
        test_faults();
        test_back_to_back();
        test_random();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller for data_memory. Turns one CPU load/store request at a time into mem_read/mem_write cycles on the 64-bit, dword-addressed data memory.
- Supports byte, half, word and dword accesses with zero or sign extension on loads.
- Sub-dword stores are done as read-modify-write.
- Sits between the datapath MEM stage and data_memory, single clock domain.

Parameters:
- MEM_WORDS, 1024, number of 64-bit words in the attached memory; used for the range check.

Ports:
- read_clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  in  1  sign-extend load result (ignored for dword and stores).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; low 8·2^size bits used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data (0 for stores and faults).
- resp_fault  out  1  valid with resp_valid; misaligned or out of range.
- mem_read  out  1  to data_memory.
- mem_write  out  1  to data_memory.
- mem_address  out  64  byte address to data_memory, always dword-aligned.
- mem_write_data  out  64  to data_memory.
- mem_read_data  in  64  from data_memory; registered, valid the cycle after mem_read.

Behaviour:
- Reset is sampled at the posedge while reset=0.
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation abandons the access: mem_write must not be asserted in the cycle after reset.
- States: IDLE, RD, MERGE, EXT, WR, RESP.
- Accept: in IDLE with req_valid=1, req_ready=1.
  - All request fields are latched.
  - req_ready=0 in every other state.
- Fault check at accept:
  - Misaligned: req_addr[size-1:0] != 0.
  - Out of range: req_addr[63:3] >= MEM_WORDS.
  - Either condition: go to RESP with resp_fault=1 and resp_rdata=0. No mem_read or mem_write is issued.
- Load path: IDLE -> RD -> EXT -> RESP -> IDLE.
  - RD: mem_read=1, mem_address={addr[63:3],3'b0}.
  - EXT: sample mem_read_data, select the lane, extend, register into resp_rdata.
  - RESP: resp_valid=1.
  - resp_valid is high exactly 3 cycles after the accept edge.
- Dword store: IDLE -> WR -> RESP. WR drives mem_write=1 and mem_write_data=req_wdata. resp_valid is high 2 cycles after accept.
- Sub-dword store: IDLE -> RD -> MERGE -> WR -> RESP.
  - MERGE replaces only the addressed lane of mem_read_data with the low bits of req_wdata. The other bytes are unchanged.
  - resp_valid is high 4 cycles after accept.
- Lanes are little-endian: byte k = bits [8k+7:8k], k = addr[2:0]. Half/word lane offset = addr[2:0]·8 bits.
- Extension:
  - req_signed=1 replicates the top bit of the selected field into the upper bits.
  - Otherwise the upper bits are zero.
- mem_read and mem_write are never both 1. Each is asserted for exactly one cycle per access.
- mem_read_data is only sampled in EXT or MERGE; it may be Z at other times.
- mem_write_data=0 and mem_address=0 whenever mem_read=0 and mem_write=0.
- resp_valid has no backpressure. resp_rdata and resp_fault hold until the next RESP and are cleared on reset.
- req_valid in non-IDLE states is ignored (not queued).

Test Plan:
- Mem word 2 = 0x8877665544332211. Load byte signed at addr 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88, resp_valid 3 cycles after accept, mem_address=0x10.
- Same word, load half unsigned at addr 0x12 -> 0x0000000000004433. Load word signed at 0x14 -> 0xFFFFFFFF88776655.
- Store byte 0xAB at addr 0x11 -> exactly one mem_read then one mem_write; word 2 becomes 0x887766554433AB11; resp_valid 4 cycles after accept.
- Store dword 0x0123456789ABCDEF at 0x18 -> no mem_read, one mem_write cycle, then dword load from 0x18 returns the same value.
- Load half at 0x13 and dword at addr 8·MEM_WORDS -> resp_fault=1, resp_rdata=0, mem_read and mem_write never asserted.
- Assert reset=0 during the MERGE state of a store byte -> memory word unchanged, next cycle state IDLE, all outputs 0, req_ready=1 after reset is released.
